display_value_encoder: RTL and testbench
========================================

# display_value_encoder

Converts a CPU-written 16-bit value into the 32-bit segment-pattern word consumed by the four-digit seven-segment multiplexer, in either hexadecimal or decimal form. It sits between the CPU's memory-mapped write port and the multiplexer's `four_digits` input. Decimal mode uses an iterative double-dabble converter, and the block exposes a ready/busy handshake toward the bus.

## Interface

**Parameters**
- `DASH_PATTERN`, default `8'h40`: segment pattern shown on every digit on decimal overflow (segment g only).

**Ports**
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  write strobe; accepted only when `wr_ready`=1.
- `wr_data`  in  16  value to display.
- `wr_mode`  in  1  0 = hexadecimal, 1 = decimal.
- `wr_dp`  in  4  decimal-point enable per digit; bit i controls digit i.
- `wr_ready`  out  1  high when IDLE and able to accept a write.
- `busy`  out  1  high while a write is being processed (`busy` = ~`wr_ready`).
- `four_digits`  out  32  segment patterns. Digit i occupies [8i+7:8i], digit 0 is least significant. Bit 0..6 = segments a..g, bit 7 = dp. Active-high.

## Operation

- **State machine:** IDLE, CONVERT, ENCODE.
- **IDLE:** `wr_ready`=1. When `wr_en`=1 on an edge:
  - latch `wr_data`, `wr_mode` and `wr_dp`;
  - go to CONVERT if `wr_mode`=1, otherwise go to ENCODE.
- **CONVERT:** 36-bit shift register, {20-bit BCD, 16-bit binary}. BCD starts at 0.
  - Each cycle, add 3 to every BCD nibble that is ≥5, then shift the whole register left by 1.
  - 4-bit iteration counter; exactly 16 cycles, then go to ENCODE.
- **ENCODE:** one cycle; registers `four_digits`, then returns to IDLE.
  - **Hex mode:** nibble i of the value maps to digit i.
  - **Decimal mode:** BCD nibbles 0..3 map to digits 0..3.
  - **Decimal overflow:** if BCD nibble 4 (ten-thousands, value > 9999) is nonzero, every digit = `DASH_PATTERN`.
  - **Decimal point:** OR'd in, `dp` bit 7 of digit i = latched `wr_dp[i]`. This applies to overflow dashes too.
- **Glyphs:** 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- **Outputs during processing:** `four_digits` holds its previous value through CONVERT. The new value is never partially visible.
- **Writes while busy:** `wr_en` while `wr_ready`=0 is ignored and dropped, not queued.

## Timing

- **Reset values:** `four_digits`=32'h0000_0000 (all blank), `wr_ready`=1, `busy`=0, state IDLE, counter 0.
- **Reset mid-operation:** conversion is aborted and the outputs take their reset values immediately (asynchronous assertion). Release is sampled on the next `clk` edge.
- **Hex latency:** write accepted at edge E0. `four_digits` updated and `wr_ready`=1 after edge E1. Throughput is one write per 2 cycles.
- **Decimal latency:** write accepted at E0. CONVERT runs on E1..E16, ENCODE on E17. `four_digits` is valid and `wr_ready`=1 after E17.
- **Ready timing:** `wr_ready` falls after E0. A write presented in the same cycle that `wr_ready` returns high is accepted at the next edge.
- **Update rate:** `four_digits` changes at most once per accepted write. It is stable between updates, so it is safe for the slow multiplexer clock domain, which samples a quasi-static word.
- **Boundary values:**
  - 0 in decimal gives digits "0000" (subject to blanking).
  - 9999 gives 0x6F6F6F6F.
  - 10000 to 65535 gives dashes.
  - Hex has no overflow.

## Configuration

- **`DISPLAY_BLANK_ZEROS_EN` defined:** in both modes, leading zero digits (digits 3..1, scanning from 3 down to the first nonzero) are encoded as 8'h00 before the dp OR.
  - Digit 0 is never blanked.
  - Overflow dashes are never blanked.
  - A blanked digit still shows its dp if `wr_dp[i]`=1.
- **Undefined:** every digit shows its glyph, including leading zeros.

## Test plan

- Hex write 16'hBEEF, `wr_dp`=0 -> `four_digits`=32'h7C79_7971 after E1; `wr_ready` low for exactly 1 cycle.
- Decimal write 1234, `wr_dp`=0 -> `four_digits`=32'h065B_4F66 after E17; `busy` high E0..E17; output unchanged during E1..E16.
- Decimal write 10000 with `wr_dp`=4'b0100 -> 32'h40C0_4040. Decimal write 9999 -> 32'h6F6F_6F6F.
- Decimal write 7, `wr_dp`=4'b0001 -> 32'h0000_0087 with `DISPLAY_BLANK_ZEROS_EN`; 32'h3F3F_3F87 without.
- Second `wr_en` (hex 16'h1111) issued at E5 of a decimal 42 conversion -> ignored; final output shows 42 (32'h3F3F_665B unblanked).
- Assert `rst` low at E8 of a decimal conversion -> `four_digits`=0, `wr_ready`=1 immediately. After release, hex write 16'h000A -> 32'h3F3F_3F77 (unblanked) / 32'h0000_0077 (blanked).

Source files
------------

// File: rtl/display_value_encoder.sv
// display_value_encoder
//
// Turns a CPU-written 16-bit value into the 32-bit segment word used by the
// four-digit seven-segment multiplexer. Hex mode encodes the four nibbles
// directly; decimal mode first runs a 16-cycle double-dabble conversion.
// The output word is written only in the single ENCODE cycle, so the
// multiplexer never sees a partially converted value.
//
// Digit i lives in four_digits[8i+7:8i]; bits 0..6 are segments a..g and
// bit 7 is the decimal point (all active-high).
//
// Optional feature macro: DISPLAY_BLANK_ZEROS_EN
//   When defined, leading zero digits (3 down to 1) are blanked in both
//   modes. Digit 0 and the overflow dashes are never blanked, and decimal
//   points are still shown on blanked digits.

module display_value_encoder #(
    parameter logic [7:0] DASH_PATTERN = 8'h40
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic        wr_mode,
    input  logic [3:0]  wr_dp,
    output logic        wr_ready,
    output logic        busy,
    output logic [31:0] four_digits
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_ENCODE  = 2'd2;

    localparam logic [3:0] LAST_ITER  = 4'd15;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Seven-segment glyph for one hex/BCD digit.
    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = 8'h3F;
            4'h1:    seg = 8'h06;
            4'h2:    seg = 8'h5B;
            4'h3:    seg = 8'h4F;
            4'h4:    seg = 8'h66;
            4'h5:    seg = 8'h6D;
            4'h6:    seg = 8'h7D;
            4'h7:    seg = 8'h07;
            4'h8:    seg = 8'h7F;
            4'h9:    seg = 8'h6F;
            4'hA:    seg = 8'h77;
            4'hB:    seg = 8'h7C;
            4'hC:    seg = 8'h39;
            4'hD:    seg = 8'h5E;
            4'hE:    seg = 8'h79;
            default: seg = 8'h71;
        endcase
        return seg;
    endfunction

    // One double-dabble iteration on {bcd[19:0], bin[15:0]}: correct every
    // BCD nibble that would overflow past 9 when doubled, then shift left.
    function automatic logic [35:0] dabble_step(input logic [35:0] r);
        logic [35:0] adj;
        adj = r;
        for (int n = 0; n < 5; n++) begin
            if (adj[16 + 4*n +: 4] >= 4'd5) begin
                adj[16 + 4*n +: 4] = adj[16 + 4*n +: 4] + 4'd3;
            end
        end
        return {adj[34:0], 1'b0};
    endfunction

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]  state_q,  state_d;
    logic        mode_q,   mode_d;
    logic [3:0]  dp_q,     dp_d;
    logic [35:0] shift_q,  shift_d;   // {BCD[19:0], binary[15:0]}
    logic [3:0]  count_q,  count_d;
    logic [31:0] digits_q, digits_d;

    // ------------------------------------------------------------------
    // Encoder datapath (only consumed in ENCODE)
    // ------------------------------------------------------------------
    logic [3:0][3:0] nib;        // digit values 3..0
    logic            overflow;   // decimal value above 9999
    logic [3:0]      blank;      // digit forced dark before the dp OR
    logic [31:0]     encoded;

    // Choose digit source: raw nibbles in hex mode, BCD result in decimal.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        nib      = '0;
        overflow = 1'b0;
        if (mode_q) begin
            nib      = shift_q[31:16];
            overflow = (shift_q[35:32] != 4'd0);
        end else begin
            nib      = shift_q[15:0];
        end
    end

`ifdef DISPLAY_BLANK_ZEROS_EN
    // Leading-zero blanking, scanning from digit 3 toward digit 1.
    always_comb begin
        blank    = '0;
        blank[3] = (nib[3] == 4'd0);
        blank[2] = blank[3] && (nib[2] == 4'd0);
        blank[1] = blank[2] && (nib[1] == 4'd0);
        if (overflow) begin
            blank = '0;
        end
    end
`else
    // Every digit shows its glyph, leading zeros included.
    always_comb begin
        blank = '0;
    end
`endif

    // Build the final segment word: glyph or dash or blank, then OR in dp.
    always_comb begin
        encoded = '0;
        for (int i = 0; i < 4; i++) begin
            if (overflow) begin
                encoded[8*i +: 8] = DASH_PATTERN;
            end else if (blank[i]) begin
                encoded[8*i +: 8] = 8'h00;
            end else begin
                encoded[8*i +: 8] = glyph(nib[i]);
            end
            encoded[8*i + 7] = encoded[8*i + 7] | dp_q[i];
        end
    end

    // ------------------------------------------------------------------
    // Control
    // ------------------------------------------------------------------

    // Next-state logic for the IDLE -> (CONVERT) -> ENCODE -> IDLE sequence.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        dp_d     = dp_q;
        shift_d  = shift_q;
        count_d  = count_q;
        digits_d = digits_q;

        case (state_q)
            ST_IDLE: begin
                // Writes are only looked at here, so writes while busy drop.
                if (wr_en) begin
                    mode_d  = wr_mode;
                    dp_d    = wr_dp;
                    shift_d = {20'd0, wr_data};
                    count_d = 4'd0;
                    state_d = wr_mode ? ST_CONVERT : ST_ENCODE;
                end
            end

            ST_CONVERT: begin
                shift_d = dabble_step(shift_q);
                count_d = count_q + 4'd1;   // wraps back to 0 after 16 steps
                if (count_q == LAST_ITER) begin
                    state_d = ST_ENCODE;
                end
            end

            ST_ENCODE: begin
                digits_d = encoded;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            mode_q   <= 1'b0;
            dp_q     <= 4'd0;
            shift_q  <= 36'd0;
            count_q  <= 4'd0;
            digits_q <= 32'd0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            mode_q   <= mode_d;
            dp_q     <= dp_d;
            shift_q  <= shift_d;
            count_q  <= count_d;
            digits_q <= digits_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wr_ready    = (state_q == ST_IDLE);
    assign busy        = ~wr_ready;
    assign four_digits = digits_q;

endmodule

// File: tb/tb_display_value_encoder.sv
// Self-checking bench for display_value_encoder: spec vectors, corner-case
// sequences (dropped write, back-to-back writes, reset mid-conversion) and
// randomized writes against an arithmetic reference model. Build with
// +define+DISPLAY_BLANK_ZEROS_EN to check the blanking variant.

module tb_display_value_encoder;

    logic        clk;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        wr_mode;
    logic [3:0]  wr_dp;
    logic        wr_ready;
    logic        busy;
    logic [31:0] four_digits;

    int total;
    int bad;

    display_value_encoder #(.DASH_PATTERN(8'h40)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_mode     (wr_mode),
        .wr_dp       (wr_dp),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .four_digits (four_digits)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [7:0] GLYPH [16] = '{
        8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
        8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
    };

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Reference model: digits from plain division / shifting.
    function automatic logic [31:0] model(input int v, input bit dec, input logic [3:0] dp);
        int         d [4];
        int         scale;
        logic [31:0] r;
        logic [7:0] g;
`ifdef DISPLAY_BLANK_ZEROS_EN
        bit         lead;
        lead = 1'b1;
`endif
        r     = '0;
        scale = 1;
        for (int i = 0; i < 4; i++) begin
            d[i]  = dec ? (v / scale) % 10 : (v >> (4 * i)) % 16;
            scale = scale * 10;
        end
        if (dec && v > 9999) begin
            for (int i = 0; i < 4; i++) r[8*i +: 8] = 8'h40 | {dp[i], 7'b0};
        end else begin
            for (int i = 3; i >= 0; i--) begin
                g = GLYPH[d[i]];
`ifdef DISPLAY_BLANK_ZEROS_EN
                if (lead && i > 0 && d[i] == 0) g = 8'h00;
                else lead = 1'b0;
`endif
                r[8*i +: 8] = g | {dp[i], 7'b0};
            end
        end
        return r;
    endfunction

    // Issue one write from a negedge with wr_ready high; report final output,
    // cycles from accepting edge to ready, and whether output held meanwhile.
    task automatic do_write(input logic [15:0] d, input logic m, input logic [3:0] dp,
                            output logic [31:0] got, output int lat, output bit held);
        logic [31:0] prev;
        prev    = four_digits;
        held    = 1'b1;
        wr_en   = 1'b1;
        wr_data = d;
        wr_mode = m;
        wr_dp   = dp;
        @(negedge clk);
        wr_en = 1'b0;
        lat   = 0;
        while (wr_ready !== 1'b1 && lat < 40) begin
            if (four_digits !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
        end
        got = four_digits;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (wr_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready"}, {31'd0, wr_ready}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] data;
        logic        mode;
        logic [3:0]  dp;
        logic [31:0] exp_plain;
        logic [31:0] exp_blank;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    initial begin
        logic [31:0] got;
        logic [31:0] exp;
        int          lat;
        bit          held;
        int          v;
        bit          m;
        logic [3:0]  dp;

        total = 0;
        bad   = 0;

        vecs[0] = '{16'hBEEF, 1'b0, 4'b0000, 32'h7C79_7971, 32'h7C79_7971};
        vecs[1] = '{16'd1234, 1'b1, 4'b0000, 32'h065B_4F66, 32'h065B_4F66};
        vecs[2] = '{16'd10000, 1'b1, 4'b0100, 32'h40C0_4040, 32'h40C0_4040};
        vecs[3] = '{16'd9999, 1'b1, 4'b0000, 32'h6F6F_6F6F, 32'h6F6F_6F6F};
        vecs[4] = '{16'd7,    1'b1, 4'b0001, 32'h3F3F_3F87, 32'h0000_0087};
        vecs[5] = '{16'd0,    1'b1, 4'b0000, 32'h3F3F_3F3F, 32'h0000_003F};
        vecs[6] = '{16'd65535, 1'b1, 4'b1000, 32'hC040_4040, 32'hC040_4040};
        vecs[7] = '{16'h000A, 1'b0, 4'b0000, 32'h3F3F_3F77, 32'h0000_0077};
        vecs[8] = '{16'h0000, 1'b0, 4'b1111, 32'hBFBF_BFBF, 32'h8080_80BF};
        vecs[9] = '{16'd100,  1'b1, 4'b0000, 32'h3F06_3F3F, 32'h0006_3F3F};

        rst     = 1'b0;
        wr_en   = 1'b0;
        wr_data = '0;
        wr_mode = 1'b0;
        wr_dp   = '0;

        // Reset state
        #12;
        check("reset_digits", four_digits, 32'h0);
        check("reset_ready", {31'd0, wr_ready}, 32'd1);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < NVEC; i++) begin
`ifdef DISPLAY_BLANK_ZEROS_EN
            exp = vecs[i].exp_blank;
`else
            exp = vecs[i].exp_plain;
`endif
            do_write(vecs[i].data, vecs[i].mode, vecs[i].dp, got, lat, held);
            check($sformatf("vec%0d_digits", i), got, exp);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].mode ? 32'd17 : 32'd1);
            check($sformatf("vec%0d_hold", i), {31'd0, held}, 32'd1);
        end

        // Write during a decimal conversion is dropped
        wr_en = 1'b1; wr_data = 16'd42; wr_mode = 1'b1; wr_dp = 4'b0000;
        @(negedge clk);
        wr_en = 1'b0;
        check("drop_busy", {31'd0, busy}, 32'd1);
        repeat (4) @(negedge clk);
        wr_en = 1'b1; wr_data = 16'h1111; wr_mode = 1'b0;
        @(negedge clk);
        wr_en = 1'b0;
        wait_ready("drop");
`ifdef DISPLAY_BLANK_ZEROS_EN
        check("drop_digits", four_digits, 32'h0000_665B);
`else
        check("drop_digits", four_digits, 32'h3F3F_665B);
`endif
        @(negedge clk);
        check("drop_not_queued", {31'd0, wr_ready}, 32'd1);

        // Back-to-back hex writes: held wr_en is re-accepted when ready returns
        wr_en = 1'b1; wr_data = 16'h1234; wr_mode = 1'b0; wr_dp = 4'b0000;
        @(negedge clk);
        check("b2b_first_busy", {31'd0, wr_ready}, 32'd0);
        wr_data = 16'h00C0;
        @(negedge clk);
        check("b2b_first_ready", {31'd0, wr_ready}, 32'd1);
        check("b2b_first_digits", four_digits, 32'h065B_4F66);
        @(negedge clk);
        wr_en = 1'b0;
        check("b2b_second_busy", {31'd0, wr_ready}, 32'd0);
        @(negedge clk);
`ifdef DISPLAY_BLANK_ZEROS_EN
        check("b2b_second_digits", four_digits, 32'h0000_393F);
`else
        check("b2b_second_digits", four_digits, 32'h3F3F_393F);
`endif

        // Asynchronous reset in the middle of a decimal conversion
        wr_en = 1'b1; wr_data = 16'd5000; wr_mode = 1'b1; wr_dp = 4'b0010;
        @(posedge clk);
        #1 wr_en = 1'b0;
        repeat (8) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("midreset_digits", four_digits, 32'h0);
        check("midreset_ready", {31'd0, wr_ready}, 32'd1);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        do_write(16'h000A, 1'b0, 4'b0000, got, lat, held);
`ifdef DISPLAY_BLANK_ZEROS_EN
        check("postreset_digits", got, 32'h0000_0077);
`else
        check("postreset_digits", got, 32'h3F3F_3F77);
`endif
        check("postreset_latency", lat, 32'd1);

        // Randomized writes against the reference model
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0:       v = $urandom_range(0, 99);
                1:       v = $urandom_range(0, 9999);
                2:       v = $urandom_range(9990, 10010);
                default: v = $urandom_range(0, 65535);
            endcase
            m  = 1'($urandom_range(0, 1));
            dp = 4'($urandom_range(0, 15));
            exp = model(v, m, dp);
            do_write(16'(v), m, dp, got, lat, held);
            check($sformatf("rand%0d_digits v=%0d mode=%0d", k, v, m), got, exp);
            check($sformatf("rand%0d_latency", k), lat, m ? 32'd17 : 32'd1);
            check($sformatf("rand%0d_hold", k), {31'd0, held}, 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
